// File: rtl/term1_po_capture.sv
// Capture stage for the term1 output vector: change-event FIFO with timestamps plus a MISR signature.
// Events are pushed on the first sample after reset and on every value change; the head is served first-word-fall-through.
module term1_po_capture #(
  parameter int              PO_W  = 10,
  parameter int              DEPTH = 8,
  parameter int              TS_W  = 16,
  parameter logic [PO_W-1:0] POLY  = 10'h009
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     in_valid,
  input  logic [PO_W-1:0]          po_in,
  input  logic                     clear_sig,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [TS_W+PO_W-1:0]     out_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     ovf,
  output logic [PO_W-1:0]          sig
);
  localparam int AW = $clog2(DEPTH);
  localparam int DW = TS_W + PO_W;

  typedef enum logic {IDLE, RUN} state_t;

  state_t          state_reg, state_next;
  logic [PO_W-1:0] last_reg;
  logic [TS_W-1:0] ts_reg;
  logic [PO_W-1:0] sig_reg, sig_next;
  logic            ovf_reg;
  logic            out_valid_reg;
  logic [DW-1:0]   out_data_reg;
  logic [AW:0]     wr_ptr_reg, rd_ptr_reg;
  logic [DW-1:0]   mem [DEPTH];

  logic            push_req, push_ok, pop, full;
  logic [AW:0]     count_now, rd_ptr_next, wr_ptr_next, count_next;
  logic [DW-1:0]   push_data;

  assign count_now   = wr_ptr_reg - rd_ptr_reg;
  assign full        = (count_now == (AW+1)'(DEPTH));
  assign pop         = out_valid_reg && out_ready;
  assign push_ok     = push_req && (!full || pop);
  assign push_data   = {ts_reg, po_in};
  assign rd_ptr_next = rd_ptr_reg + {{AW{1'b0}}, pop};
  assign wr_ptr_next = wr_ptr_reg + {{AW{1'b0}}, push_ok};
  assign count_next  = wr_ptr_next - rd_ptr_next;

  // Event qualification; IDLE has no baseline, so the first sample always produces an event.
  always_comb begin
    state_next = state_reg;
    push_req   = 1'b0;
    if (in_valid) begin
      case (state_reg)
        IDLE: begin
          push_req   = 1'b1;
          state_next = RUN;
        end
        RUN: push_req = (po_in != last_reg);
        default: state_next = IDLE;
      endcase
    end
  end

  always_comb begin
    sig_next = sig_reg;
    if (clear_sig)
      sig_next = '0;
    else if (in_valid)
      sig_next = {sig_reg[PO_W-2:0], 1'b0} ^ (sig_reg[PO_W-1] ? POLY : '0) ^ po_in;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg     <= IDLE;
      last_reg      <= '0;
      ts_reg        <= '0;
      sig_reg       <= '0;
      ovf_reg       <= 1'b0;
      out_valid_reg <= 1'b0;
      wr_ptr_reg    <= '0;
      rd_ptr_reg    <= '0;
    end else begin
      state_reg     <= state_next;
      sig_reg       <= sig_next;
      wr_ptr_reg    <= wr_ptr_next;
      rd_ptr_reg    <= rd_ptr_next;
      out_valid_reg <= (count_next != '0);
      if (in_valid)
        ts_reg <= ts_reg + 1'b1;
      // Baseline follows the sample even when the event itself is dropped.
      if (push_req)
        last_reg <= po_in;
      if (push_req && !push_ok)
        ovf_reg <= 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (push_ok)
      mem[wr_ptr_reg[AW-1:0]] <= push_data;
  end

  // Head register: forward the incoming event when it becomes the head, otherwise read memory.
  always_ff @(posedge clock) begin
    if (push_ok && (wr_ptr_reg == rd_ptr_next))
      out_data_reg <= push_data;
    else
      out_data_reg <= mem[rd_ptr_next[AW-1:0]];
  end

  assign out_valid = out_valid_reg;
  assign out_data  = out_data_reg;
  assign count     = count_now;
  assign ovf       = ovf_reg;
  assign sig       = sig_reg;
endmodule
